// File: rtl/jts16_motor_pkg.sv
// Shared types and constants for the cabinet motor model.
//   axis_st_e     : per-axis state (run / homing to left stop / homing to centre)
//   LIM_R/C/L     : bit positions inside each 3-bit active-low switch group
//   DEF_*         : legacy default limits, centre window and homing speed
package jts16_motor_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHomeL = 2'd1,
        StHomeC = 2'd2
    } axis_st_e;

    localparam int unsigned LIM_R = 0;
    localparam int unsigned LIM_C = 1;
    localparam int unsigned LIM_L = 2;

    localparam logic [15:0] DEF_LEFTLIM  = 16'h2000;
    localparam logic [15:0] DEF_RIGHTLIM = 16'he000;
    localparam logic [15:0] DEF_CENTER   = 16'h8000;
    localparam logic [15:0] DEF_HSTEP    = 16'h0100;
    localparam logic [7:0]  DEF_CWIN     = 8'h00;

endpackage

// File: rtl/jts16_motor_axis.sv
// One motor axis: rate-limited velocity ramp, clamped position integrator,
// homing sequencer and registered active-low limit switches.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick_i     : one-cycle frame strobe; all motion happens on it
//   ctrl_i     : bit3 direction (1 = right), bits2:0 speed code
//   home_i     : one-cycle homing request
//   pos_o      : current position
//   limpos_o   : {left, centre, right} switches, active low, one cycle behind pos
//   busy_o     : high while homing
module jts16_motor_axis
    import jts16_motor_pkg::*;
#(
    parameter int unsigned    PW       = 16,
    parameter int unsigned    SHIFT    = 5,
    parameter int unsigned    ACCEL    = 16,
    parameter logic [PW-1:0]  LEFTLIM  = DEF_LEFTLIM,
    parameter logic [PW-1:0]  RIGHTLIM = DEF_RIGHTLIM,
    parameter logic [PW-1:0]  CENTER   = DEF_CENTER,
    parameter logic [7:0]     CWIN     = DEF_CWIN,
    parameter logic [PW-1:0]  HSTEP    = DEF_HSTEP
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_i,
    input  logic [3:0]    ctrl_i,
    input  logic          home_i,
    output logic [PW-1:0] pos_o,
    output logic [2:0]    limpos_o,
    output logic          busy_o
);

    // Two guard bits so pos + vel and pos +/- HSTEP never wrap before clamping.
    localparam int unsigned XW = PW + 2;

    localparam logic signed [XW-1:0] AccelX  = XW'(ACCEL);
    localparam logic signed [XW-1:0] LeftX   = $signed({2'b00, LEFTLIM});
    localparam logic signed [XW-1:0] RightX  = $signed({2'b00, RIGHTLIM});
    localparam logic signed [XW-1:0] CenterX = $signed({2'b00, CENTER});
    localparam logic signed [XW-1:0] HstepX  = $signed({2'b00, HSTEP});

    function automatic logic [2:0] lim_of(input logic [PW-1:0] p);
        logic [7:0] hi;
        logic [7:0] ctr;
        logic [7:0] cdiff;
        logic [2:0] sw;
        hi    = p[PW-1:PW-8];
        ctr   = CENTER[PW-1:PW-8];
        cdiff = (hi >= ctr) ? hi - ctr : ctr - hi;
        sw        = 3'b111;
        sw[LIM_L] = ~(p == LEFTLIM);
        sw[LIM_C] = ~(cdiff <= CWIN);
        sw[LIM_R] = ~(p == RIGHTLIM);
        return sw;
    endfunction

    logic [PW-1:0]        pos_q, pos_d;
    logic signed [PW-1:0] vel_q, vel_d;
    axis_st_e             st_q, st_d;
    logic [2:0]           lim_q, lim_d;

    logic [2:0]           mag;
    logic signed [XW-1:0] tgt_mag, tgt, vel_x, diff, pos_x, sum, home_sum;
    logic signed [PW-1:0] vel_n;

    always_comb begin
        // Left speed codes are inverted: code 0 left is the fastest.
        mag      = ctrl_i[3] ? ctrl_i[2:0] : ~ctrl_i[2:0];
        tgt_mag  = $signed({{(XW-3){1'b0}}, mag} << SHIFT);
        tgt      = ctrl_i[3] ? tgt_mag : -tgt_mag;
        vel_x    = $signed({{2{vel_q[PW-1]}}, vel_q});
        diff     = tgt - vel_x;

        if (ACCEL == 0 || (diff <= AccelX && diff >= -AccelX)) begin
            vel_n = PW'(tgt);
        end else if (diff > 0) begin
            vel_n = PW'(vel_x + AccelX);
        end else begin
            vel_n = PW'(vel_x - AccelX);
        end

        pos_x    = $signed({2'b00, pos_q});
        sum      = pos_x + $signed({{2{vel_n[PW-1]}}, vel_n});
        home_sum = (st_q == StHomeL) ? pos_x - HstepX : pos_x + HstepX;
    end

    always_comb begin
        pos_d = pos_q;
        vel_d = vel_q;
        st_d  = st_q;
        lim_d = lim_of(pos_q);

        case (st_q)
            StRun: begin
                if (tick_i) begin
                    if (sum < LeftX) begin
                        pos_d = LEFTLIM;
                        vel_d = '0;
                    end else if (sum > RightX) begin
                        pos_d = RIGHTLIM;
                        vel_d = '0;
                    end else begin
                        pos_d = sum[PW-1:0];
                        vel_d = vel_n;
                    end
                end
                // A coincident tick still applies the run update above.
                if (home_i) begin
                    st_d  = StHomeL;
                    vel_d = '0;
                end
            end
            StHomeL: begin
                if (tick_i) begin
                    if (home_sum <= LeftX) begin
                        pos_d = LEFTLIM;
                        st_d  = StHomeC;
                    end else begin
                        pos_d = home_sum[PW-1:0];
                    end
                end
            end
            StHomeC: begin
                if (tick_i) begin
                    if (home_sum >= CenterX) begin
                        pos_d = CENTER;
                        vel_d = '0;
                        st_d  = StRun;
                    end else begin
                        pos_d = home_sum[PW-1:0];
                    end
                end
            end
            default: begin
                st_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= CENTER;
            vel_q <= '0;
            st_q  <= StRun;
            lim_q <= lim_of(CENTER);
        end else begin
            pos_q <= pos_d;
            vel_q <= vel_d;
            st_q  <= st_d;
            lim_q <= lim_d;
        end
    end

    assign pos_o    = pos_q;
    assign limpos_o = lim_q;
    assign busy_o   = (st_q != StRun);

endmodule

// File: rtl/jts16_motor_axes.sv
// Multi-axis cabinet motor model placed between the CPU motor latch and the
// I/O input port. Derives the frame tick from vint and runs CH independent axes.
//   clk, rst_n : clock, asynchronous active-low reset
//   vint_i     : vertical interrupt level; rising edge is the frame tick
//   ctrl_i     : 4 bits per channel {dir, speed[2:0]}
//   home_i     : per-channel homing request pulse
//   pos_o      : PW bits per channel
//   limpos_o   : 3 bits per channel {left, centre, right}, active low
//   busy_o     : per-channel homing flag
module jts16_motor_axes
    import jts16_motor_pkg::*;
#(
    parameter int unsigned    CH       = 2,
    parameter int unsigned    PW       = 16,
    parameter int unsigned    SHIFT    = 5,
    parameter int unsigned    ACCEL    = 16,
    parameter logic [PW-1:0]  LEFTLIM  = DEF_LEFTLIM,
    parameter logic [PW-1:0]  RIGHTLIM = DEF_RIGHTLIM,
    parameter logic [PW-1:0]  CENTER   = DEF_CENTER,
    parameter logic [7:0]     CWIN     = DEF_CWIN,
    parameter logic [PW-1:0]  HSTEP    = DEF_HSTEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vint_i,
    input  logic [4*CH-1:0]   ctrl_i,
    input  logic [CH-1:0]     home_i,
    output logic [PW*CH-1:0]  pos_o,
    output logic [3*CH-1:0]   limpos_o,
    output logic [CH-1:0]     busy_o
);

    if (!(LEFTLIM < CENTER && CENTER < RIGHTLIM)) begin : g_bad_limits
        $error("jts16_motor_axes: need LEFTLIM < CENTER < RIGHTLIM");
    end
    if (HSTEP == 0) begin : g_bad_hstep
        $error("jts16_motor_axes: HSTEP must be non-zero");
    end
    if ((7 << SHIFT) >= (1 << (PW - 1))) begin : g_bad_shift
        $error("jts16_motor_axes: top speed does not fit in signed velocity");
    end

    logic vint_q;
    logic tick;

    // Reset as if vint were already high, so a level held across reset release
    // is not mistaken for a frame; vint must drop and rise again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vint_q <= 1'b1;
        end else begin
            vint_q <= vint_i;
        end
    end

    assign tick = vint_i & ~vint_q;

    for (genvar i = 0; i < CH; i++) begin : g_axis
        jts16_motor_axis #(
            .PW       (PW),
            .SHIFT    (SHIFT),
            .ACCEL    (ACCEL),
            .LEFTLIM  (LEFTLIM),
            .RIGHTLIM (RIGHTLIM),
            .CENTER   (CENTER),
            .CWIN     (CWIN),
            .HSTEP    (HSTEP)
        ) u_axis (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_i   (tick),
            .ctrl_i   (ctrl_i[4*i +: 4]),
            .home_i   (home_i[i]),
            .pos_o    (pos_o[PW*i +: PW]),
            .limpos_o (limpos_o[3*i +: 3]),
            .busy_o   (busy_o[i])
        );
    end

endmodule

// File: tb/tb_jts16_motor_axes.sv
// Bench for jts16_motor_axes: two instances (default ACCEL=16, and ACCEL=0 with
// LEFTLIM=0) checked every cycle against a frame-level arithmetic model, plus a
// vector table and hand-written homing / reset sequences.
module tb_jts16_motor_axes;

    localparam int RIGHT  = 'he000;
    localparam int CENTER = 'h8000;
    localparam int HSTEP  = 'h0100;
    localparam int CWIN   = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vint;
    logic [7:0]  ctrl_a, ctrl_b;
    logic [1:0]  home_a, home_b;
    logic [31:0] pos_a, pos_b;
    logic [5:0]  lim_a, lim_b;
    logic [1:0]  busy_a, busy_b;

    always #5 clk = ~clk;

    jts16_motor_axes u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .vint_i   (vint),
        .ctrl_i   (ctrl_a),
        .home_i   (home_a),
        .pos_o    (pos_a),
        .limpos_o (lim_a),
        .busy_o   (busy_a)
    );

    jts16_motor_axes #(
        .ACCEL   (0),
        .LEFTLIM (16'h0000)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .vint_i   (vint),
        .ctrl_i   (ctrl_b),
        .home_i   (home_b),
        .pos_o    (pos_b),
        .limpos_o (lim_b),
        .busy_o   (busy_b)
    );

    int vecs = 0;
    int miss = 0;

    // Reference model: mode 0 = running, 1 = homing left, 2 = homing to centre.
    int         accel_m[2] = '{16, 0};
    int         left_m[2]  = '{'h2000, 0};
    int         m_pos[2][2];
    int         m_vel[2][2];
    int         m_mode[2][2];
    logic [2:0] m_lim[2][2];
    bit         m_vprev;

    function automatic logic [2:0] lim_of(int p, int l);
        logic [2:0] r;
        int d;
        d = (p / 256) - (CENTER / 256);
        if (d < 0) d = -d;
        r[2] = (p != l);
        r[1] = !(d <= CWIN);
        r[0] = (p != RIGHT);
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                m_pos[d][c]  = CENTER;
                m_vel[d][c]  = 0;
                m_mode[d][c] = 0;
                m_lim[d][c]  = lim_of(CENTER, left_m[d]);
            end
        end
        m_vprev = 1'b1;
    endtask

    task automatic model_update();
        bit tick;
        logic [3:0] cn;
        bit hm;
        int code, t, v, np;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick = vint && !m_vprev;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                cn = (d == 0) ? ctrl_a[4*c +: 4] : ctrl_b[4*c +: 4];
                hm = (d == 0) ? home_a[c] : home_b[c];
                m_lim[d][c] = lim_of(m_pos[d][c], left_m[d]);
                case (m_mode[d][c])
                    0: begin
                        if (tick) begin
                            code = int'(cn[2:0]);
                            t = cn[3] ? code * 32 : -((7 - code) * 32);
                            v = m_vel[d][c];
                            if (accel_m[d] == 0 || (t - v <= accel_m[d] && v - t <= accel_m[d]))
                                v = t;
                            else if (t > v)
                                v = v + accel_m[d];
                            else
                                v = v - accel_m[d];
                            np = m_pos[d][c] + v;
                            if (np < left_m[d]) begin
                                m_pos[d][c] = left_m[d];
                                m_vel[d][c] = 0;
                            end else if (np > RIGHT) begin
                                m_pos[d][c] = RIGHT;
                                m_vel[d][c] = 0;
                            end else begin
                                m_pos[d][c] = np;
                                m_vel[d][c] = v;
                            end
                        end
                        if (hm) begin
                            m_mode[d][c] = 1;
                            m_vel[d][c]  = 0;
                        end
                    end
                    1: begin
                        if (tick) begin
                            np = m_pos[d][c] - HSTEP;
                            if (np <= left_m[d]) begin
                                m_pos[d][c]  = left_m[d];
                                m_mode[d][c] = 2;
                            end else begin
                                m_pos[d][c] = np;
                            end
                        end
                    end
                    default: begin
                        if (tick) begin
                            np = m_pos[d][c] + HSTEP;
                            if (np >= CENTER) begin
                                m_pos[d][c]  = CENTER;
                                m_vel[d][c]  = 0;
                                m_mode[d][c] = 0;
                            end else begin
                                m_pos[d][c] = np;
                            end
                        end
                    end
                endcase
            end
        end
        m_vprev = vint;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [15:0] p;
        logic [2:0]  l;
        logic        b;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                p = (d == 0) ? pos_a[16*c +: 16] : pos_b[16*c +: 16];
                l = (d == 0) ? lim_a[3*c +: 3] : lim_b[3*c +: 3];
                b = (d == 0) ? busy_a[c] : busy_b[c];
                chk($sformatf("model pos dut%0d ch%0d", d, c), 32'(p), 32'(m_pos[d][c]));
                chk($sformatf("model limpos dut%0d ch%0d", d, c), 32'(l), 32'(m_lim[d][c]));
                chk($sformatf("model busy dut%0d ch%0d", d, c), 32'(b),
                    32'(m_mode[d][c] != 0));
            end
        end
    endtask

    // Inputs are set before the call; the model steps on the same edge as the DUT.
    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_tick();
        vint = 1'b0;
        cyc();
        vint = 1'b1;
        cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vint  = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    typedef struct {
        int          ticks;
        logic [3:0]  ctrl;
        logic [15:0] exp_pos;
        logic [2:0]  exp_lim;
    } tv_t;

    tv_t tv[7];

    initial begin
        // ACCEL=0 / LEFTLIM=0 instance, channel 0; channel 1 holds still.
        tv[0] = '{10,  4'hF, 16'h88C0, 3'b111};
        tv[1] = '{5,   4'h7, 16'h88C0, 3'b111};
        tv[2] = '{4,   4'h0, 16'h8540, 3'b111};
        tv[3] = '{3,   4'h8, 16'h8540, 3'b111};
        tv[4] = '{2,   4'hC, 16'h8640, 3'b111};
        tv[5] = '{160, 4'h0, 16'h0000, 3'b011};
        tv[6] = '{1,   4'hF, 16'h00E0, 3'b111};

        rst_n  = 1'b0;
        vint   = 1'b1;
        ctrl_a = 8'h88;
        ctrl_b = 8'h88;
        home_a = 2'b00;
        home_b = 2'b00;
        model_reset();
        @(negedge clk);
        chk("reset pos", pos_a, 32'h8000_8000);
        chk("reset limpos", 32'(lim_a), 32'h2D);
        chk("reset busy", 32'(busy_a), 32'h0);

        // Release with vint high: no tick may occur.
        ctrl_a = 8'h00;
        ctrl_b = 8'h00;
        rst_n  = 1'b1;
        repeat (3) cyc();
        chk("no tick on held vint", pos_a, 32'h8000_8000);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            ctrl_a = {4'h8, tv[i].ctrl};
            ctrl_b = {4'h8, tv[i].ctrl};
            repeat (tv[i].ticks) do_tick();
            vint = 1'b0;
            cyc();
            chk($sformatf("table %0d pos", i), 32'(pos_b[15:0]), 32'(tv[i].exp_pos));
            chk($sformatf("table %0d limpos", i), 32'(lim_b[2:0]), 32'(tv[i].exp_lim));
            chk($sformatf("table %0d ch1 pos", i), 32'(pos_b[31:16]), 32'h8000);
        end

        // Acceleration ramp up to 0xE0 then back down to zero at 16 per frame.
        do_reset();
        ctrl_a = 8'h8F;
        repeat (14) do_tick();
        vint = 1'b0;
        cyc();
        chk("ramp up pos", 32'(pos_a[15:0]), 32'h8690);
        ctrl_a = 8'h87;
        repeat (14) do_tick();
        vint = 1'b0;
        cyc();
        chk("ramp down pos", 32'(pos_a[15:0]), 32'h8C40);

        // Homing channel 0 from centre.
        do_reset();
        ctrl_a = 8'h88;
        home_a = 2'b01;
        cyc();
        home_a = 2'b00;
        chk("home busy", 32'(busy_a), 32'h1);
        repeat (96) do_tick();
        vint = 1'b0;
        cyc();
        chk("home left pos", 32'(pos_a[15:0]), 32'h2000);
        chk("home left limpos", 32'(lim_a[2:0]), 32'h3);
        chk("home left busy", 32'(busy_a), 32'h1);
        repeat (10) do_tick();
        vint   = 1'b0;
        home_a = 2'b01;
        ctrl_a = 8'h80;
        cyc();
        home_a = 2'b00;
        repeat (86) do_tick();
        vint = 1'b0;
        cyc();
        chk("home done pos", pos_a, 32'h8000_8000);
        chk("home done busy", 32'(busy_a), 32'h0);

        // Asynchronous reset in the middle of the left sweep.
        home_a = 2'b01;
        cyc();
        home_a = 2'b00;
        repeat (10) do_tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async reset pos", 32'(pos_a[15:0]), 32'h8000);
        chk("async reset busy", 32'(busy_a), 32'h0);
        model_reset();
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("held vint after reset", 32'(pos_a[15:0]), 32'h8000);
        vint = 1'b0;
        cyc();
        vint = 1'b1;
        cyc();
        chk("first tick after reset", 32'(pos_a[15:0]), 32'h7FF0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            vint   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                ctrl_a = 8'($urandom);
                ctrl_b = 8'($urandom);
            end
            home_a[0] = ($urandom_range(0, 63) == 0);
            home_a[1] = ($urandom_range(0, 63) == 0);
            home_b[0] = ($urandom_range(0, 63) == 0);
            home_b[1] = ($urandom_range(0, 63) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
